tlul_sram_adapter: RTL

- TL-UL device-side responder downstream of the ibex_tlul instruction and data host ports.
- Accepts A-channel requests (tl_h2d_t), drives a single-port SRAM with 1-cycle read latency, and returns ordered D-channel responses (tl_d2h_t).
- Buffers responses so the host may back-pressure d_ready without stalling the SRAM.

---
 rtl/tlul_pkg.sv | 50 +++++
 rtl/tlul_sram_adapter_pkg.sv | 79 +++++++
 rtl/tlul_sram_rsp_fifo.sv | 65 ++++++
 rtl/tlul_sram_adapter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions (32-bit data, 8-bit source ID) shared by host and device.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_AUW = 8;
    localparam int unsigned TL_DUW = 8;

    // A-channel opcodes
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    // D-channel opcodes
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    localparam logic [TL_DUW-1:0] TL_D_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_adapter_pkg.sv
// Types and helpers for the TL-UL SRAM adapter.
// Macro TLUL_SRAM_ADAPTER_BYTE_WRITE_EN enables sub-word PutPartialData writes.
package tlul_sram_adapter_pkg;

    import tlul_pkg::*;

    // One buffered D-channel response; opcode is already the D opcode
    typedef struct packed {
        logic [2:0]        opcode;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic              error;
        logic [TL_DW-1:0]  data;
    } rsp_entry_t;

    // Request metadata held while the SRAM read completes
    typedef struct packed {
        logic [2:0]        opcode;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic              error;
        logic              rd;
    } pipe_meta_t;

    // Expand a byte mask to a bit mask
    function automatic logic [31:0] mask_to_bits(input logic [3:0] mask);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

    // Byte lanes a transfer of this size/offset may touch
    function automatic logic [3:0] size_window(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] win;
        case (size)
            2'd0:    win = 4'b0001 << addr_lo;
            2'd1:    win = 4'b0011 << addr_lo;
            default: win = 4'b1111;
        endcase
        return win;
    endfunction

    // Non-empty run of adjacent set bits
    function automatic logic mask_contiguous(input logic [3:0] mask);
        logic ok;
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns 1 when the request is legal (address range checked separately)
    function automatic logic legal_check(input logic [2:0] opcode, input logic [1:0] size,
                                         input logic [1:0] addr_lo, input logic [3:0] mask);
        logic op_ok, size_ok, align_ok, mask_ok;
        op_ok   = (opcode == Get) || (opcode == PutFullData) || (opcode == PutPartialData);
        size_ok = (size <= 2'd2);
        case (size)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~addr_lo[0];
            default: align_ok = (addr_lo == 2'b00);
        endcase
        mask_ok = 1'b1;
        if (opcode == PutFullData) mask_ok = (mask == 4'hF);
`ifdef TLUL_SRAM_ADAPTER_BYTE_WRITE_EN
        if (opcode == PutPartialData)
            mask_ok = mask_contiguous(mask) && ((mask & ~size_window(size, addr_lo)) == 4'h0);
`else
        if (opcode == PutPartialData) mask_ok = (mask == 4'hF);
`endif
        return op_ok && size_ok && align_ok && mask_ok;
    endfunction

endpackage

// File: rtl/tlul_sram_rsp_fifo.sv
// In-order response buffer for the TL-UL SRAM adapter.
module tlul_sram_rsp_fifo
    import tlul_sram_adapter_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  rsp_entry_t      wdata_i,
    input  logic            pop_i,
    output rsp_entry_t      rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    rsp_entry_t      mem_q [Depth];
    rsp_entry_t      mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer, count and storage next-state; head is always visible
    always_comb begin
        full_o   = (count_q == CntW'(Depth));
        empty_o  = (count_q == '0);
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + CntW'(1);
        if (!do_push && do_pop) count_d = count_q - CntW'(1);
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wdata_i;
        rdata_o = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    // Control state; flushed by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity comes from count
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tlul_sram_adapter.sv
// TL-UL device responder in front of a 1-cycle-latency single-port SRAM.
// Macro TLUL_SRAM_ADAPTER_BYTE_WRITE_EN enables sub-word PutPartialData writes.
module tlul_sram_adapter
    import tlul_pkg::*;
    import tlul_sram_adapter_pkg::*;
#(
    parameter int unsigned SramAw   = 12,
    parameter int unsigned Depth    = 2,
    parameter bit          ErrOnOob = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              req_o,
    output logic              we_o,
    output logic [SramAw-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       wmask_o,
    input  logic [31:0]       rdata_i
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned OccW = CntW + 1;

    logic            pipe_valid_q, pipe_valid_d;
    pipe_meta_t      pipe_q, pipe_d;
    pipe_meta_t      meta_c;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    rsp_entry_t      fifo_wdata, fifo_rdata;
    logic            a_ready_c, a_ack_c, legal_c, oob_c;
    logic            unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

    // Accept decision and legality of the presented request
    always_comb begin
        oob_c     = ErrOnOob && ((tl_i.a_address >> (SramAw + 2)) != 32'h0);
        legal_c   = legal_check(tl_i.a_opcode, tl_i.a_size, tl_i.a_address[1:0], tl_i.a_mask) && !oob_c;
        a_ready_c = rst_ni && ((OccW'(fifo_count) + OccW'(pipe_valid_q)) < OccW'(Depth));
        a_ack_c   = tl_i.a_valid && a_ready_c;
        meta_c.opcode = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
        meta_c.size   = tl_i.a_size;
        meta_c.source = tl_i.a_source;
        meta_c.error  = !legal_c;
        meta_c.rd     = legal_c && (tl_i.a_opcode == Get);
    end

    // SRAM access in the accept cycle; errored requests never touch the array
    always_comb begin
        req_o   = a_ack_c && legal_c;
        we_o    = req_o && (tl_i.a_opcode != Get);
        addr_o  = tl_i.a_address[SramAw+1:2];
        wdata_o = tl_i.a_data;
`ifdef TLUL_SRAM_ADAPTER_BYTE_WRITE_EN
        wmask_o = mask_to_bits(tl_i.a_mask);
`else
        wmask_o = '1;
`endif
    end

    // Pipe stage captures metadata alongside the outstanding SRAM read
    always_comb begin
        pipe_valid_d = a_ack_c;
        pipe_d       = a_ack_c ? meta_c : pipe_q;
    end

    // Pipe stage register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= 1'b0;
            pipe_q       <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_q       <= pipe_d;
        end
    end

    // Merge read data into the response and manage FIFO handshakes
    always_comb begin
        fifo_wdata.opcode = pipe_q.opcode;
        fifo_wdata.size   = pipe_q.size;
        fifo_wdata.source = pipe_q.source;
        fifo_wdata.error  = pipe_q.error;
        fifo_wdata.data   = pipe_q.rd ? rdata_i : 32'h0;
        fifo_pop          = !fifo_empty && tl_i.d_ready;
        fifo_push         = pipe_valid_q && (!fifo_full || fifo_pop);
    end

    tlul_sram_rsp_fifo #(
        .Depth (Depth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // D channel presents the FIFO head
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = !fifo_empty;
        tl_o.d_opcode = fifo_rdata.opcode;
        tl_o.d_param  = 3'h0;
        tl_o.d_size   = fifo_rdata.size;
        tl_o.d_source = fifo_rdata.source;
        tl_o.d_sink   = '0;
        tl_o.d_data   = fifo_rdata.data;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = fifo_rdata.error;
        tl_o.a_ready  = a_ready_c;
    end

endmodule
